dnn_layer_seq: RTL and testbench

Layer sequencer that sits directly upstream of the single-neuron DNN master, the block that computes one output activation.
- The CPU programs one fully-connected layer through an Avalon-MM slave: base addresses, input length, output length and ReLU flag.
- The sequencer then drives the neuron master once per output neuron, advancing the bias, weight-row and output addresses each time.
- A CPU read of the status register stalls until the whole layer has been written to SDRAM.

---
 rtl/dnn_layer_seq.sv | 158 +++++++++++++++
 tb/tb_dnn_layer_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_layer_seq.sv
// Layer sequencer: runs the single-neuron DNN master once per output neuron of a layer.
// Optional cycle counter at offset 8 is built when DNN_SEQ_PERF_EN is defined.
module dnn_layer_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  output logic        slave_waitrequest,
  output logic [31:0] bias_v_addr,
  output logic [31:0] weight_m_addr,
  output logic [31:0] activ_addr,
  output logic [31:0] out_activ_addr,
  output logic [31:0] activ_len,
  output logic [31:0] relu,
  output logic        enable,
  input  logic        operating
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWdone = 2'd2;
  localparam logic [1:0] StNext  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] bias_q, weight_q, activ_q, out_q, n_q, m_q, relu_q;
  logic [31:0] bias_run_q, weight_run_q, out_run_q, activ_run_q, len_run_q, relu_run_q;
  logic [31:0] step_q, m_run_q, j_q;
  logic [31:0] rdata_q, rdata_d, perf_val;
  logic        start, last, rd_accept;

  assign start     = slave_write && (slave_address == 4'd0) && (state_q == StIdle);
  assign last      = (j_q + 32'd1) == m_run_q;
  assign rd_accept = slave_read && !slave_waitrequest;

  // Only the status read blocks; it is released once the layer is back in idle.
  assign slave_waitrequest = slave_read && (slave_address == 4'd0) && (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && (m_q != 32'd0)) state_d = StIssue;
      StIssue: if (operating) state_d = StWdone;
      StWdone: if (!operating) state_d = StNext;
      StNext:  state_d = last ? StIdle : StIssue;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Shadow registers accept writes in any state; the running layer works from its snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q   <= '0;
      weight_q <= '0;
      activ_q  <= '0;
      out_q    <= '0;
      n_q      <= '0;
      m_q      <= '0;
      relu_q   <= '0;
    end else if (slave_write) begin
      case (slave_address)
        4'd1:    bias_q   <= slave_writedata;
        4'd2:    weight_q <= slave_writedata;
        4'd3:    activ_q  <= slave_writedata;
        4'd4:    out_q    <= slave_writedata;
        4'd5:    n_q      <= slave_writedata;
        4'd6:    m_q      <= slave_writedata;
        4'd7:    relu_q   <= slave_writedata;
        default: ;
      endcase
    end
  end

  // Weight row advances by 4*N per neuron through accumulation, so no multiplier is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_run_q   <= '0;
      weight_run_q <= '0;
      out_run_q    <= '0;
      activ_run_q  <= '0;
      len_run_q    <= '0;
      relu_run_q   <= '0;
      step_q       <= '0;
      m_run_q      <= '0;
      j_q          <= '0;
    end else if (start) begin
      bias_run_q   <= bias_q;
      weight_run_q <= weight_q;
      out_run_q    <= out_q;
      activ_run_q  <= activ_q;
      len_run_q    <= n_q;
      relu_run_q   <= relu_q;
      step_q       <= n_q << 2;
      m_run_q      <= m_q;
      j_q          <= '0;
    end else if (state_q == StNext) begin
      bias_run_q   <= bias_run_q + 32'd4;
      weight_run_q <= weight_run_q + step_q;
      out_run_q    <= out_run_q + 32'd4;
      j_q          <= j_q + 32'd1;
    end
  end

`ifdef DNN_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (start) begin
      perf_q <= '0;
    end else if ((state_q != StIdle) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_val = perf_q;
`else
  assign perf_val = '0;
`endif

  always_comb begin
    rdata_d = '0;
    case (slave_address)
      4'd1:    rdata_d = bias_q;
      4'd2:    rdata_d = weight_q;
      4'd3:    rdata_d = activ_q;
      4'd4:    rdata_d = out_q;
      4'd5:    rdata_d = n_q;
      4'd6:    rdata_d = m_q;
      4'd7:    rdata_d = relu_q;
      4'd8:    rdata_d = perf_val;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rdata_q <= '0;
    else if (rd_accept) rdata_q <= rdata_d;
  end

  assign slave_readdata = rdata_q;
  assign bias_v_addr    = bias_run_q;
  assign weight_m_addr  = weight_run_q;
  assign out_activ_addr = out_run_q;
  assign activ_addr     = activ_run_q;
  assign activ_len      = len_run_q;
  assign relu           = relu_run_q;
  assign enable         = (state_q == StIssue);

endmodule

// File: tb/tb_dnn_layer_seq.sv
// Directed bench for dnn_layer_seq: a model neuron master plus a per-neuron address scoreboard.
module tb_dnn_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  slave_address;
  logic        slave_read, slave_write;
  logic [31:0] slave_writedata, slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] bias_v_addr, weight_m_addr, activ_addr, out_activ_addr, activ_len, relu;
  logic        enable, operating;

  dnn_layer_seq dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .slave_address     (slave_address),
    .slave_read        (slave_read),
    .slave_write       (slave_write),
    .slave_writedata   (slave_writedata),
    .slave_readdata    (slave_readdata),
    .slave_waitrequest (slave_waitrequest),
    .bias_v_addr       (bias_v_addr),
    .weight_m_addr     (weight_m_addr),
    .activ_addr        (activ_addr),
    .out_activ_addr    (out_activ_addr),
    .activ_len         (activ_len),
    .relu              (relu),
    .enable            (enable),
    .operating         (operating)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] bias, weight, out, activ, len, relu;
  } nrn_t;

  nrn_t exp_q[$];
  nrn_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  // Edge index: at edge e the old value of cyc is e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model neuron master: operating rises rise_lat edges after enable is first seen, holds for hold.
  int rise_lat = 1;
  int hold     = 10;
  int m_st, wcnt, hcnt;
  int fall_cyc, rise_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operating <= 1'b0;
      m_st      <= 0;
    end else begin
      case (m_st)
        0: if (enable) begin
          if (rise_lat <= 1) begin
            operating <= 1'b1; hcnt <= hold - 1; m_st <= 2; rise_cyc <= cyc;
          end else begin
            wcnt <= rise_lat - 2; m_st <= 1;
          end
        end
        1: if (wcnt == 0) begin
          operating <= 1'b1; hcnt <= hold - 1; m_st <= 2; rise_cyc <= cyc;
        end else wcnt <= wcnt - 1;
        default: if (hcnt == 0) begin
          operating <= 1'b0; m_st <= 0; fall_cyc <= cyc;
        end else hcnt <= hcnt - 1;
      endcase
    end
  end

  // Monitor: capture parameter outputs at each enable rise and measure pulse length.
  logic en_prev = 1'b0;
  int   hi_cnt = 0, last_len = 0, en_fall_edge = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
      hi_cnt  = 0;
    end else begin
      if (enable && !en_prev) begin
        obs_q.push_back('{bias_v_addr, weight_m_addr, out_activ_addr, activ_addr, activ_len, relu});
        hi_cnt = 1;
      end else if (enable) begin
        hi_cnt++;
      end
      if (!enable && en_prev) begin
        last_len     = hi_cnt;
        en_fall_edge = cyc - 1;
      end
      en_prev = enable;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  // Read completes at the first edge with waitrequest low; data is registered at that edge.
  task automatic rd(input logic [3:0] a, output logic [31:0] d, output int waits, output int acc);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1; waits = 0; #1;
    while (slave_waitrequest && waits < 300) begin
      @(negedge clk); #1;
      waits++;
    end
    check("read_completes", {31'd0, slave_waitrequest}, 32'd0);
    acc = cyc;
    @(posedge clk); #1;
    d = slave_readdata;
    slave_read = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] b, w, ac, o, n, m, r);
    for (int j = 0; j < int'(m); j++)
      exp_q.push_back('{b + 32'(4 * j), w + 32'(4 * n * j), o + 32'(4 * j), ac, n, r});
  endtask

  task automatic start_layer(input logic [31:0] b, w, ac, o, n, m, r);
    wr(4'd1, b); wr(4'd2, w); wr(4'd3, ac); wr(4'd4, o);
    wr(4'd5, n); wr(4'd6, m); wr(4'd7, r);
    push_exp(b, w, ac, o, n, m, r);
    wr(4'd0, 32'd0);
  endtask

  task automatic compare_layer(input string tag);
    nrn_t e, o;
    check({tag, "_enable_rises"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_bias"}, o.bias, e.bias);
      check({tag, "_weight"}, o.weight, e.weight);
      check({tag, "_out"}, o.out, e.out);
      check({tag, "_activ"}, o.activ, e.activ);
      check({tag, "_len"}, o.len, e.len);
      check({tag, "_relu"}, o.relu, e.relu);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  logic [31:0] rdata;
  int          waits, acc;
  logic [31:0] perf_exp;

  initial begin
    rst_n = 1'b0; slave_address = '0; slave_read = 1'b0; slave_write = 1'b0;
    slave_writedata = '0;
    #12;
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_waitreq", {31'd0, slave_waitrequest}, 32'd0);
    check("rst_readdata", slave_readdata, 32'd0);
    check("rst_bias", bias_v_addr, 32'd0);
    check("rst_weight", weight_m_addr, 32'd0);
    check("rst_out", out_activ_addr, 32'd0);
    check("rst_len", activ_len, 32'd0);
    check("rst_relu", relu, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Normal layer; status read is accepted 3 edges after the last operating fall edge.
    start_layer(32'h100, 32'h200, 32'h300, 32'h400, 32'd3, 32'd2, 32'd1);
    rd(4'd0, rdata, waits, acc);
    check("status_data", rdata, 32'd0);
    check("status_release_edge", acc, fall_cyc + 3);
    compare_layer("normal");

    // M = 0: no neuron run, no stall.
    start_layer(32'h500, 32'h600, 32'h700, 32'h800, 32'd2, 32'd0, 32'd0);
    rd(4'd0, rdata, waits, acc);
    check("m0_waits", waits, 32'd0);
    repeat (5) @(negedge clk);
    compare_layer("m0");

    // Writes while busy touch only the shadows; a busy start is dropped.
    start_layer(32'h100, 32'h200, 32'h300, 32'h400, 32'd3, 32'd2, 32'd0);
    repeat (3) @(negedge clk);
    wr(4'd1, 32'hDEAD);
    wr(4'd0, 32'd0);
    rd(4'd0, rdata, waits, acc);
    repeat (20) @(negedge clk);
    compare_layer("busy");
    push_exp(32'hDEAD, 32'h200, 32'h300, 32'h400, 32'd3, 32'd2, 32'd0);
    wr(4'd0, 32'd0);
    rd(4'd0, rdata, waits, acc);
    compare_layer("restart");

    // Late operating: enable holds until one edge after operating rises.
    rise_lat = 5; hold = 3;
    start_layer(32'h10, 32'h20, 32'h30, 32'h40, 32'd4, 32'd1, 32'd1);
    rd(4'd0, rdata, waits, acc);
    check("late_en_cycles", last_len, 32'd6);
    check("late_en_drop_edge", en_fall_edge, rise_cyc + 1);
    compare_layer("late");

    // N = 0 with address wrap-around.
    rise_lat = 1; hold = 2;
    start_layer(32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFC, 32'd0, 32'd2, 32'd1);
    rd(4'd0, rdata, waits, acc);
    compare_layer("wrap");

    // Perf: ISSUE (rise_lat+1) + WDONE (hold) + NEXT (1) = 7 cycles.
    hold = 4;
`ifdef DNN_SEQ_PERF_EN
    perf_exp = 32'd7;
`else
    perf_exp = 32'd0;
`endif
    start_layer(32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'd1, 32'd1, 32'd0);
    rd(4'd0, rdata, waits, acc);
    compare_layer("perf_layer");
    repeat (3) @(negedge clk);
    rd(4'd8, rdata, waits, acc);
    check("perf_count", rdata, perf_exp);
    rd(4'd9, rdata, waits, acc);
    check("unmapped_read", rdata, 32'd0);

    // Asynchronous reset in the middle of ISSUE.
    rise_lat = 50;
    start_layer(32'h100, 32'h200, 32'h300, 32'h400, 32'd3, 32'd1, 32'd1);
    repeat (3) @(negedge clk);
    check("pre_rst_enable", {31'd0, enable}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_enable", {31'd0, enable}, 32'd0);
    check("midrst_bias", bias_v_addr, 32'd0);
    check("midrst_weight", weight_m_addr, 32'd0);
    check("midrst_out", out_activ_addr, 32'd0);
    check("midrst_len", activ_len, 32'd0);
    exp_q.delete();
    obs_q.delete();
    @(negedge clk); rst_n = 1'b1;
    rise_lat = 1;
    rd(4'd0, rdata, waits, acc);
    check("postrst_waits", waits, 32'd0);
    check("postrst_data", rdata, 32'd0);
    repeat (5) @(negedge clk);
    check("postrst_no_run", obs_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
